// File: rtl/regbus_arbiter_if.sv
// Register bus handshake bundle: request fields toward the slave side,
// one-cycle ready pulse with read data and error flag back.
interface regbus_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              addr_valid;
   logic              reg_write;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_ready;
   logic [DATA_W-1:0] reg_rdata;
   logic              reg_err;

   modport master (
      output addr_valid, reg_write, reg_addr, reg_wdata,
      input  reg_ready, reg_rdata
   );

   modport slave (
      input  addr_valid, reg_write, reg_addr, reg_wdata,
      output reg_ready, reg_rdata, reg_err
   );
endinterface

// File: rtl/regbus_arbiter.sv
// Two-master round-robin register bus arbiter; the grant is held until
// the slave answers or the access times out.
module regbus_arbiter #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       TIMEOUT  = 64,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic             Clk,
   input  logic             Rst,
   regbus_arbiter_if.slave  m0,
   regbus_arbiter_if.slave  m1,
   regbus_arbiter_if.master s,
   output logic             grant,
   output logic [7:0]       timeout_cnt
);
   localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic [15:0]       timer_q, timer_d;
   logic [7:0]        tcnt_q, tcnt_d;
   logic              sv_q, sv_d;
   logic              swr_q, swr_d;
   logic [ADDR_W-1:0] sa_q, sa_d;
   logic [DATA_W-1:0] swd_q, swd_d;
   logic              rdy0_q, rdy0_d, rdy1_q, rdy1_d;
   logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic              er0_q, er0_d, er1_q, er1_d;

   logic              pick;
   logic              fin;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      timer_d  = timer_q;
      tcnt_d   = tcnt_q;
      sv_d     = 1'b0;
      swr_d    = swr_q;
      sa_d     = sa_q;
      swd_d    = swd_q;
      rdy0_d   = 1'b0;
      rdy1_d   = 1'b0;
      rd0_d    = '0;
      rd1_d    = '0;
      er0_d    = 1'b0;
      er1_d    = 1'b0;
      fin      = 1'b0;
      rsp_data = '0;
      rsp_err  = 1'b0;
      // On a tie the requester not granted last wins
      pick = m0.addr_valid ? (m1.addr_valid & ~grant_q) : 1'b1;

      unique case (state_q)
         IDLE: begin
            if (m0.addr_valid || m1.addr_valid) begin
               state_d = BUSY;
               grant_d = pick;
               timer_d = '0;
               sv_d    = 1'b1;
               swr_d   = pick ? m1.reg_write : m0.reg_write;
               sa_d    = pick ? m1.reg_addr  : m0.reg_addr;
               swd_d   = pick ? m1.reg_wdata : m0.reg_wdata;
            end
         end
         BUSY: begin
            timer_d = timer_q + 16'd1;
            if (s.reg_ready) begin
               fin      = 1'b1;
               rsp_data = swr_q ? '0 : s.reg_rdata;
            end else if (timer_q == TMAX) begin
               fin      = 1'b1;
               rsp_data = ERR_DATA;
               rsp_err  = 1'b1;
               if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
            end else begin
               sv_d = 1'b1;
            end
            if (fin) state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (fin) begin
         rdy0_d = ~grant_q;
         rdy1_d = grant_q;
         rd0_d  = grant_q ? '0 : rsp_data;
         rd1_d  = grant_q ? rsp_data : '0;
         er0_d  = ~grant_q & rsp_err;
         er1_d  = grant_q & rsp_err;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         grant_q <= 1'b1;
         timer_q <= '0;
         tcnt_q  <= '0;
         sv_q    <= 1'b0;
         swr_q   <= 1'b0;
         sa_q    <= '0;
         swd_q   <= '0;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
         er0_q   <= 1'b0;
         er1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         timer_q <= timer_d;
         tcnt_q  <= tcnt_d;
         sv_q    <= sv_d;
         swr_q   <= swr_d;
         sa_q    <= sa_d;
         swd_q   <= swd_d;
         rdy0_q  <= rdy0_d;
         rdy1_q  <= rdy1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
         er0_q   <= er0_d;
         er1_q   <= er1_d;
      end
   end

   assign s.addr_valid  = sv_q;
   assign s.reg_write   = swr_q;
   assign s.reg_addr    = sa_q;
   assign s.reg_wdata   = swd_q;
   assign m0.reg_ready  = rdy0_q;
   assign m0.reg_rdata  = rd0_q;
   assign m0.reg_err    = er0_q;
   assign m1.reg_ready  = rdy1_q;
   assign m1.reg_rdata  = rd1_q;
   assign m1.reg_err    = er1_q;
   assign grant         = grant_q;
   assign timeout_cnt   = tcnt_q;
endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a timestamp-based access model.
module tb_regbus_arbiter;
   localparam int unsigned TO  = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       grant;
   logic [7:0] timeout_cnt;

   regbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
   regbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
   regbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

   regbus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERR)
   ) dut (
      .Clk(Clk), .Rst(Rst),
      .m0(m0_if), .m1(m1_if), .s(s_if),
      .grant(grant), .timeout_cnt(timeout_cnt)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic r0, w0; logic [31:0] a0, d0;
      logic r1, w1; logic [31:0] a1, d1;
      logic sr; logic [31:0] srd;
      logic sv, swr; logic [31:0] sa, swd;
      logic k0; logic [31:0] q0; logic e0;
      logic k1; logic [31:0] q1; logic e1;
      logic g; logic [7:0] tc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic r0, w0, input logic [31:0] a0, d0,
      input logic r1, w1, input logic [31:0] a1, d1,
      input logic sr, input logic [31:0] srd,
      input logic sv, swr, input logic [31:0] sa, swd,
      input logic k0, input logic [31:0] q0, input logic e0,
      input logic k1, input logic [31:0] q1, input logic e1,
      input logic g, input logic [7:0] tc);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.sr = sr; v.srd = srd;
      v.sv = sv; v.swr = swr; v.sa = sa; v.swd = swd;
      v.k0 = k0; v.q0 = q0; v.e0 = e0;
      v.k1 = k1; v.q1 = q1; v.e1 = e1;
      v.g = g; v.tc = tc;
      return v;
   endfunction

   task automatic chk(input string t, input string nm,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s %s: got %0h, want %0h (t=%0t)",
                  t, nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(
      input logic r0, w0, input logic [31:0] a0, d0,
      input logic r1, w1, input logic [31:0] a1, d1,
      input logic sr, input logic [31:0] srd);
      m0_if.addr_valid = r0; m0_if.reg_write = w0;
      m0_if.reg_addr   = a0; m0_if.reg_wdata = d0;
      m1_if.addr_valid = r1; m1_if.reg_write = w1;
      m1_if.reg_addr   = a1; m1_if.reg_wdata = d1;
      s_if.reg_ready   = sr; s_if.reg_rdata  = srd;
      s_if.reg_err     = 1'b0;
   endtask

   task automatic check_outs(
      input string t, input logic sv, swr, input logic [31:0] sa, swd,
      input logic k0, input logic [31:0] q0, input logic e0,
      input logic k1, input logic [31:0] q1, input logic e1,
      input logic g, input logic [7:0] tc);
      chk(t, "s_addr_valid", s_if.addr_valid, sv);
      if (sv) begin
         chk(t, "s_reg_addr", s_if.reg_addr, sa);
         chk(t, "s_reg_write", s_if.reg_write, swr);
         chk(t, "s_reg_wdata", s_if.reg_wdata, swd);
      end
      chk(t, "m0_ready", m0_if.reg_ready, k0);
      chk(t, "m0_rdata", m0_if.reg_rdata, q0);
      chk(t, "m0_err", m0_if.reg_err, e0);
      chk(t, "m1_ready", m1_if.reg_ready, k1);
      chk(t, "m1_rdata", m1_if.reg_rdata, q1);
      chk(t, "m1_err", m1_if.reg_err, e1);
      chk(t, "grant", grant, g);
      chk(t, "timeout_cnt", timeout_cnt, tc);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      Rst = 1'b1;
      step();
      step();
      Rst = 1'b0;
   endtask

   // Random-phase model: each access is a set of timestamps
   int          nxt, st, dn, rc, who, lat, tc_m, g_m, x;
   bit          act, to_hit, busy;
   logic        ewr;
   logic [31:0] ea, ewd, erd, edat;
   logic        req[2], wr[2];
   logic [31:0] ad[2], wd[2];
   int          rel[2];
   logic        sr_r;
   logic [31:0] srd_r;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      Rst = 1'b1;
      step();
      step();
      check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("reset", "s_reg_write", s_if.reg_write, 0);
      chk("reset", "s_reg_addr", s_if.reg_addr, 0);
      chk("reset", "s_reg_wdata", s_if.reg_wdata, 0);

      // Tie from reset: m0 write first, then m1 read
      tbl.push_back(mk(1,1,'h4,'hA5, 1,0,'h8,0, 0,0,
                       1,1,'h4,'hA5, 0,0,0, 0,0,0, 0,0));
      tbl.push_back(mk(1,1,'h4,'hA5, 1,0,'h8,0, 1,'hFFFF_FFFF,
                       0,0,0,0, 1,0,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0, 1,0,'h8,0, 0,0,
                       0,0,0,0, 0,0,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0, 1,0,'h8,0, 0,0,
                       1,0,'h8,0, 0,0,0, 0,0,0, 1,0));
      tbl.push_back(mk(0,0,0,0, 1,0,'h8,0, 1,'hCAFE_0001,
                       0,0,0,0, 0,0,0, 1,'hCAFE_0001,0, 1,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,'h77,
                       0,0,0,0, 0,0,0, 0,0,0, 1,0));
      // Single read m0, slave answers on 2nd busy cycle
      tbl.push_back(mk(1,0,'h10,0, 0,0,0,0, 0,0,
                       1,0,'h10,0, 0,0,0, 0,0,0, 0,0));
      tbl.push_back(mk(1,0,'h10,0, 0,0,0,0, 0,0,
                       1,0,'h10,0, 0,0,0, 0,0,0, 0,0));
      tbl.push_back(mk(1,0,'h10,0, 0,0,0,0, 1,'h1234_5678,
                       0,0,0,0, 1,'h1234_5678,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                       0,0,0,0, 0,0,0, 0,0,0, 0,0));
      // Timeout on m1
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0,0,0,0, 1,0,'h20,0, 0,0,
                          1,0,'h20,0, 0,0,0, 0,0,0, 1,0));
      tbl.push_back(mk(0,0,0,0, 1,0,'h20,0, 0,0,
                       0,0,0,0, 0,0,0, 1,ERR,1, 1,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,'h99,
                       0,0,0,0, 0,0,0, 0,0,0, 1,1));
      // Slave ready in the same cycle the timer expires
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1,0,'h30,0, 0,0,0,0, 0,0,
                          1,0,'h30,0, 0,0,0, 0,0,0, 0,1));
      tbl.push_back(mk(1,0,'h30,0, 0,0,0,0, 1,'h5555_AAAA,
                       0,0,0,0, 1,'h5555_AAAA,0, 0,0,0, 0,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                       0,0,0,0, 0,0,0, 0,0,0, 0,1));

      Rst = 1'b0;
      foreach (tbl[i]) begin
         drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
               tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1,
               tbl[i].sr, tbl[i].srd);
         step();
         check_outs($sformatf("vec%0d", i),
                    tbl[i].sv, tbl[i].swr, tbl[i].sa, tbl[i].swd,
                    tbl[i].k0, tbl[i].q0, tbl[i].e0,
                    tbl[i].k1, tbl[i].q1, tbl[i].e1,
                    tbl[i].g, tbl[i].tc);
      end

      // Reset in the 2nd busy cycle aborts the access silently
      drive(0, 0, 0, 0, 1, 0, 'h40, 0, 0, 0);
      step();
      check_outs("rst_b1", 1, 0, 'h40, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step();
      check_outs("rst_b2", 1, 0, 'h40, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      Rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check_outs("rst_hit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      Rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1111);
      step();
      check_outs("rst_stray", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check_outs("rst_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

      // Both held continuously: grants alternate starting at m0
      drive(1, 1, 'h100, 'h11, 1, 0, 'h200, 'h22, 1, 'hABCD_0000);
      for (int k = 0; k < 6; k++) begin
         int w;
         w = k % 2;
         step();
         check_outs($sformatf("rr%0d_req", k), 1, (w == 0),
                    (w == 0) ? 32'h100 : 32'h200,
                    (w == 0) ? 32'h11 : 32'h22,
                    0, 0, 0, 0, 0, 0, w[0], 0);
         step();
         check_outs($sformatf("rr%0d_rsp", k), 0, 0, 0, 0,
                    (w == 0), 0, 0,
                    (w == 1), (w == 1) ? 32'hABCD_0000 : 32'h0, 0,
                    w[0], 0);
         step();
         check_outs($sformatf("rr%0d_idle", k), 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, w[0], 0);
      end

      // Randomized run against the timestamp model
      do_reset();
      nxt = 0; g_m = 1; tc_m = 0; act = 0;
      st = 0; dn = 0; rc = -1; who = 0; to_hit = 0;
      ewr = 0; ea = 0; ewd = 0; erd = 0; edat = 0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; wr[i] = 0; ad[i] = 0; wd[i] = 0;
         rel[i] = 1 << 30;
      end
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (req[i] && c >= rel[i]) begin
               req[i] = 0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1;
               wr[i]  = 1'($urandom_range(0, 1));
               ad[i]  = $urandom;
               wd[i]  = $urandom;
               rel[i] = 1 << 30;
            end
         end
         if (c == nxt) begin
            if (req[0] || req[1]) begin
               if (req[0] && req[1]) who = 1 - g_m;
               else who = req[1] ? 1 : 0;
               g_m = who;
               act = 1;
               st  = c + 1;
               ewr = wr[who]; ea = ad[who]; ewd = wd[who];
               erd = $urandom;
               lat = $urandom_range(1, TO + 1);
               if (lat <= int'(TO)) begin
                  rc = c + lat; dn = c + lat + 1; to_hit = 0;
                  edat = ewr ? 32'h0 : erd;
               end else begin
                  rc = -1; dn = c + TO + 1; to_hit = 1;
                  edat = ERR;
               end
               nxt = dn + 1;
               rel[who] = dn + 1;
            end else begin
               nxt = c + 1;
            end
         end
         busy = act && c >= st && c < dn;
         if (act && c == rc) begin
            sr_r = 1; srd_r = erd;
         end else begin
            sr_r  = !busy && ($urandom_range(0, 7) == 0);
            srd_r = $urandom;
         end
         drive(req[0], wr[0], ad[0], wd[0],
               req[1], wr[1], ad[1], wd[1], sr_r, srd_r);
         step();
         x = c + 1;
         if (act && x == dn && to_hit && tc_m < 255) tc_m++;
         check_outs($sformatf("rnd%0d", x),
                    act && x >= st && x < dn, ewr, ea, ewd,
                    act && x == dn && who == 0,
                    (act && x == dn && who == 0) ? edat : 32'h0,
                    act && x == dn && who == 0 && to_hit,
                    act && x == dn && who == 1,
                    (act && x == dn && who == 1) ? edat : 32'h0,
                    act && x == dn && who == 1 && to_hit,
                    g_m[0], 8'(tc_m));
      end

      // 300 timeouts: counter saturates at 255
      do_reset();
      drive(0, 0, 0, 0, 1, 0, 'h50, 0, 0, 0);
      for (int k = 0; k < 300; k++) begin
         for (int b = 0; b < int'(TO); b++) begin
            step();
            chk("sat", "s_addr_valid", s_if.addr_valid, 1);
         end
         step();
         chk("sat", "m1_ready", m1_if.reg_ready, 1);
         chk("sat", "m1_rdata", m1_if.reg_rdata, ERR);
         chk("sat", "m1_err", m1_if.reg_err, 1);
         chk("sat", "m0_ready", m0_if.reg_ready, 0);
         chk("sat", "timeout_cnt", timeout_cnt,
             (k + 1 > 255) ? 32'd255 : 32'(k + 1));
         step();
         chk("sat", "m1_ready_off", m1_if.reg_ready, 0);
         chk("sat", "s_valid_off", s_if.addr_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regbus_arbiter.md
# regbus_arbiter

Two-master round-robin arbiter that shares one register bus slave port. Requester 0 is the AXI4-Lite-to-regbus bridge; requester 1 is a second on-chip master, such as the miner control sequencer or a debug UART. The arbiter serialises accesses and holds the grant until the slave answers. A timeout counter guarantees every request completes, even when the slave never asserts ready.

## Interface
Parameters:
- ADDR_W, 32, register address width
- DATA_W, 32, register data width
- TIMEOUT, 64, cycles in BUSY before the access is aborted (legal range 2..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out access

Ports:
- Clk  in  1  clock; all logic is on the rising edge
- Rst  in  1  synchronous, active-high reset
- m0_addr_valid  in  1  requester 0 access request; held high, fields stable, until m0_reg_ready
- m0_reg_write  in  1  1 = write, 0 = read
- m0_reg_addr  in  ADDR_W  access address
- m0_reg_wdata  in  DATA_W  write data
- m0_reg_ready  out  1  one-cycle completion pulse
- m0_reg_rdata  out  DATA_W  read data; valid only while m0_reg_ready = 1
- m0_reg_err  out  1  asserted with m0_reg_ready when the access timed out
- m1_*  same seven ports, for requester 1
- s_addr_valid  out  1  slave request; held high until s_reg_ready or timeout
- s_reg_write, s_reg_addr, s_reg_wdata  out  1/ADDR_W/DATA_W  forwarded fields of the granted requester
- s_reg_ready  in  1  slave completion
- s_reg_rdata  in  DATA_W  slave read data; sampled when s_reg_ready = 1
- grant  out  1  index of the requester that was granted last
- timeout_cnt  out  8  saturating count of timed-out accesses since reset

## Operation
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - Selects a requester from the requests sampled this cycle.
  - If both request, the one not equal to grant wins (round-robin). A single requester always wins.
  - On a selection: latch write, addr and wdata into the s_* registers, set grant, clear the timer, go to BUSY.
- BUSY:
  - s_addr_valid = 1 and the s_* fields stay constant.
  - Timer increments each cycle.
  - If s_reg_ready = 1: latch s_reg_rdata, set err = 0, go to RESP.
  - Else if timer == TIMEOUT-1: latch ERR_DATA, set err = 1, saturating-increment timeout_cnt, go to RESP.
  - s_reg_ready has priority over timeout when both happen in the same cycle.
- RESP:
  - s_addr_valid = 0.
  - The granted requester's reg_ready = 1, with latched rdata and err; the other requester sees all zeros.
  - Always go to IDLE next cycle. No grant is made in RESP, which gives requesters one cycle to drop addr_valid.
- Output gating:
  - m*_reg_rdata and m*_reg_err are 0 whenever the matching m*_reg_ready = 0.
  - s_reg_rdata is ignored outside BUSY, and s_reg_ready is ignored outside BUSY (stray pulses are dropped).
- Writes return rdata = 0 on normal completion. A timed-out write returns ERR_DATA with err = 1.
- A requester that deasserts addr_valid before completion is a protocol violation. The access still runs to completion and the ready pulse is still issued.

## Timing
- Reset values:
  - state = IDLE; grant = 1, so m0 wins the first tie.
  - timeout_cnt = 0, timer = 0.
  - All outputs 0: s_addr_valid, s_reg_write, s_reg_addr, s_reg_wdata, m0/m1 reg_ready, reg_rdata and reg_err.
- Reset has priority over everything else. Asserting it mid-access:
  - aborts the access immediately;
  - s_addr_valid drops the cycle after the reset edge;
  - no ready pulse is ever issued for the aborted access.
- Latency: request sampled in IDLE at cycle N.
  - s_addr_valid is high from N+1.
  - If the slave answers in cycle N+k (k ≥ 1), m_reg_ready = 1 in cycle N+k+1.
  - Back in IDLE at N+k+2.
  - Minimum turnaround is 3 cycles per access.
- Timeout: with no slave answer, s_addr_valid is high for exactly TIMEOUT cycles. m_reg_ready (err = 1) follows in the next cycle.
- Back-to-back sharing: with both requesters held high continuously, grants strictly alternate. No requester waits more than one access.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Single read, m0: addr 0x10, slave ready on its 2nd BUSY cycle with rdata 0x1234_5678 -> s_addr_valid high 2 cycles; m0_reg_ready for 1 cycle with rdata 0x1234_5678 and err 0; m1 outputs stay 0.
- Simultaneous requests from reset: m0 write addr 0x4 wdata 0xA5, m1 read addr 0x8 -> m0 served first (grant = 0), then m1 (grant = 1); s_reg_addr sequence 0x4, 0x8.
- Continuous requests from both for 6 accesses -> grants 0,1,0,1,0,1; each m*_reg_ready is exactly one cycle wide.
- Timeout with TIMEOUT = 4 and the slave silent -> s_addr_valid high 4 cycles; m1_reg_ready with rdata 0xDEAD_BEEF and err 1; timeout_cnt increments 0 -> 1. Repeat 300 times -> timeout_cnt saturates at 255.
- s_reg_ready in the same cycle the timer expires -> normal completion, err 0, timeout_cnt unchanged.
- Rst asserted in the 2nd BUSY cycle -> next cycle s_addr_valid = 0 and state IDLE; no m*_reg_ready pulse; a stray s_reg_ready arriving afterwards is ignored; the first tie after reset goes to m0.
